reg_cmd_bridge: RTL and testbench

- Parametrised byte-stream-to-register-bus bridge; next generation of the main command decoder.
- Pops command bytes from the host command FIFO, decodes header, address and length, and drives the register bus.
- Returns read data to the host FIFO with TX back-pressure.
- Generalised address width, length width and read latency; adds length clamping against the register's declared size, header resync and an optional inter-byte timeout.

---
 rtl/reg_cmd_bridge_if.sv | 47 ++++
 rtl/reg_cmd_bridge.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_reg_cmd_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_bridge_if.sv
// reg_cmd_bridge_if
//   Bundles the host command FIFO handshake and the register bus of
//   reg_cmd_bridge.
//   master : bridge side (pops RX bytes, pushes TX bytes, drives reg bus)
//   slave  : environment side (FIFOs and register file)
//   cmdfifo_rxf/rd/din    RX FIFO, first-word-fall-through
//   cmdfifo_txe/wr/dout   TX FIFO, txe=1 means full
//   cmdfifo_isout         read data phase in progress
//   reg_*                 register bus (address, size lookup, strobes, data)
interface reg_cmd_bridge_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_BYTES  = 2
);
  localparam int LEN_W = 8 * LEN_BYTES;

  logic                  cmdfifo_rxf;
  logic                  cmdfifo_rd;
  logic [7:0]            cmdfifo_din;
  logic                  cmdfifo_txe;
  logic                  cmdfifo_wr;
  logic [7:0]            cmdfifo_dout;
  logic                  cmdfifo_isout;
  logic [ADDR_WIDTH-1:0] reg_address;
  logic [ADDR_WIDTH-1:0] reg_hypaddress;
  logic [LEN_W-1:0]      reg_hyplen;
  logic [LEN_W-1:0]      reg_size;
  logic [LEN_W-1:0]      reg_bytecnt;
  logic [7:0]            reg_datao;
  logic [7:0]            reg_datai;
  logic                  reg_read;
  logic                  reg_write;
  logic                  reg_addrvalid;

  modport master (
    input  cmdfifo_rxf, cmdfifo_din, cmdfifo_txe, reg_hyplen, reg_datai,
    output cmdfifo_rd, cmdfifo_wr, cmdfifo_dout, cmdfifo_isout,
           reg_address, reg_hypaddress, reg_size, reg_bytecnt, reg_datao,
           reg_read, reg_write, reg_addrvalid
  );

  modport slave (
    output cmdfifo_rxf, cmdfifo_din, cmdfifo_txe, reg_hyplen, reg_datai,
    input  cmdfifo_rd, cmdfifo_wr, cmdfifo_dout, cmdfifo_isout,
           reg_address, reg_hypaddress, reg_size, reg_bytecnt, reg_datao,
           reg_read, reg_write, reg_addrvalid
  );
endinterface

// File: rtl/reg_cmd_bridge.sv
// reg_cmd_bridge
//   Byte-stream to register-bus bridge. Pops command bytes from the host
//   RX FIFO (header, optional extended address, length LSB first, write
//   data), drives register write/read strobes and returns read data to the
//   host TX FIFO honouring back-pressure. The length is clamped against the
//   register's declared size (reg_hyplen, 0 = unlimited); clamped write
//   bytes are consumed silently, clamped read bytes return 0x00.
// Ports:
//   clk          clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   bus          reg_cmd_bridge_if.master (FIFO handshake + register bus)
//   err_timeout  one-cycle pulse when a stalled command is aborted
// Build option:
//   REG_CMD_BRIDGE_TIMEOUT_EN  enables the inter-byte timeout; otherwise the
//   bridge waits indefinitely and err_timeout is constant 0.
module reg_cmd_bridge #(
  parameter int ADDR_WIDTH     = 6,
  parameter int LEN_BYTES      = 2,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  reg_cmd_bridge_if.master       bus,
  output logic                   err_timeout
);
  localparam int LEN_W = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_LEN,
    S_WR_DATA,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT
  } state_e;

  state_e                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      size_q, size_d;
  logic [LEN_W-1:0]      eff_q, eff_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      bytecnt_q, bytecnt_d;
  logic [7:0]            datao_q, datao_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [1:0]            lidx_q, lidx_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic                  addrvalid_q, addrvalid_d;
  logic                  isout_q, isout_d;

`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  err_q, err_d;
`endif

  logic             need_byte;
  logic             pop;
  logic             wr_go;
  logic             in_range;
  logic             last_idx;
  logic [LEN_W-1:0] full_len;
  logic [LEN_W-1:0] clamp_len;

  // Pop and push are combinational so the FWFT byte is consumed on the same
  // edge it is sampled, and a push never coincides with a full TX FIFO.
  always_comb begin
    need_byte = (state_q inside {S_IDLE, S_ADDR_HI, S_LEN, S_WR_DATA});
    pop       = reset_n & bus.cmdfifo_rxf & need_byte;
    wr_go     = (state_q == S_RD_OUT) & ~bus.cmdfifo_txe;
    in_range  = (idx_q < eff_q);
    last_idx  = (idx_q == (size_q - LEN_W'(1)));
    full_len  = size_q | (LEN_W'(bus.cmdfifo_din) << {lidx_q, 3'b000});
    clamp_len = ((bus.reg_hyplen != '0) && (full_len > bus.reg_hyplen))
                ? bus.reg_hyplen : full_len;
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    size_d      = size_q;
    eff_d       = eff_q;
    idx_d       = idx_q;
    bytecnt_d   = bytecnt_q;
    datao_d     = datao_q;
    rdata_d     = rdata_q;
    lidx_d      = lidx_q;
    wcnt_d      = wcnt_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    addrvalid_d = addrvalid_q;
    isout_d     = isout_q;
`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Bytes without bit7 set are consumed and dropped to regain sync.
        if (pop && bus.cmdfifo_din[7]) begin
          is_write_d = bus.cmdfifo_din[6];
          addr_d     = ADDR_WIDTH'(bus.cmdfifo_din[5:0]);
          size_d     = '0;
          lidx_d     = '0;
          if (ADDR_WIDTH > 6) begin
            state_d = S_ADDR_HI;
          end else begin
            addrvalid_d = 1'b1;
            state_d     = S_LEN;
          end
        end
      end

      S_ADDR_HI: begin
        if (pop) begin
          // Truncation drops extended-address bits beyond ADDR_WIDTH.
          addr_d      = ADDR_WIDTH'({bus.cmdfifo_din, addr_q[5:0]});
          addrvalid_d = 1'b1;
          state_d     = S_LEN;
        end
      end

      S_LEN: begin
        if (pop) begin
          size_d = full_len;
          if (lidx_q == 2'(LEN_BYTES - 1)) begin
            eff_d = clamp_len;
            idx_d = '0;
            if (full_len == '0) begin
              addrvalid_d = 1'b0;
              state_d     = S_IDLE;
            end else if (is_write_q) begin
              state_d = S_WR_DATA;
            end else begin
              isout_d = 1'b1;
              state_d = S_RD_REQ;
            end
          end else begin
            lidx_d = lidx_q + 2'd1;
          end
        end
      end

      S_WR_DATA: begin
        if (pop) begin
          if (in_range) begin
            write_d   = 1'b1;
            datao_d   = bus.cmdfifo_din;
            bytecnt_d = idx_q;
          end
          if (last_idx) begin
            addrvalid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      S_RD_REQ: begin
        bytecnt_d = idx_q;
        if (in_range) begin
          read_d  = 1'b1;
          wcnt_d  = '0;
          state_d = S_RD_WAIT;
        end else begin
          rdata_d = '0;
          state_d = S_RD_OUT;
        end
      end

      S_RD_WAIT: begin
        // Sample READ_LATENCY cycles after the cycle reg_read was high.
        if (wcnt_q == 3'(READ_LATENCY)) begin
          rdata_d = bus.reg_datai;
          state_d = S_RD_OUT;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end

      S_RD_OUT: begin
        if (wr_go) begin
          if (last_idx) begin
            addrvalid_d = 1'b0;
            isout_d     = 1'b0;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_RD_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
    // Counts consecutive empty-RX cycles while a command is half received;
    // any pop or leaving these states restarts it.
    if ((state_q inside {S_ADDR_HI, S_LEN, S_WR_DATA}) && !bus.cmdfifo_rxf) begin
      if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
        tcnt_d      = '0;
        err_d       = 1'b1;
        addrvalid_d = 1'b0;
        state_d     = S_IDLE;
      end else begin
        tcnt_d = tcnt_q + TCNT_W'(1);
      end
    end else begin
      tcnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      eff_q       <= '0;
      idx_q       <= '0;
      bytecnt_q   <= '0;
      datao_q     <= '0;
      rdata_q     <= '0;
      lidx_q      <= '0;
      wcnt_q      <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      addrvalid_q <= 1'b0;
      isout_q     <= 1'b0;
`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
      tcnt_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      eff_q       <= eff_d;
      idx_q       <= idx_d;
      bytecnt_q   <= bytecnt_d;
      datao_q     <= datao_d;
      rdata_q     <= rdata_d;
      lidx_q      <= lidx_d;
      wcnt_q      <= wcnt_d;
      write_q     <= write_d;
      read_q      <= read_d;
      addrvalid_q <= addrvalid_d;
      isout_q     <= isout_d;
`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.cmdfifo_rd     = pop;
  assign bus.cmdfifo_wr     = wr_go;
  assign bus.cmdfifo_dout   = rdata_q;
  assign bus.cmdfifo_isout  = isout_q;
  assign bus.reg_address    = addr_q;
  assign bus.reg_hypaddress = addr_q;
  assign bus.reg_size       = size_q;
  assign bus.reg_bytecnt    = bytecnt_q;
  assign bus.reg_datao      = datao_q;
  assign bus.reg_read       = read_q;
  assign bus.reg_write      = write_q;
  assign bus.reg_addrvalid  = addrvalid_q;

`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reg_cmd_bridge.sv
`timescale 1ns/1ps
module tb_reg_cmd_bridge;
  localparam int AW = 8;
  localparam int LB = 2;
  localparam int LW = 8 * LB;
  localparam int RL = 2;
`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic err_timeout;

  always #5 clk = ~clk;

  reg_cmd_bridge_if #(.ADDR_WIDTH(AW), .LEN_BYTES(LB)) bus ();

  reg_cmd_bridge #(
    .ADDR_WIDTH(AW), .LEN_BYTES(LB), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] idx;
    logic [LW-1:0] size;
    logic [7:0]    data;
  } ev_t;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned  host_q[$];
  ev_t           exp_wr[$];
  ev_t           exp_rd[$];
  logic [7:0]    exp_out[$];
  logic [LW-1:0] hyp [256];

  bit         pop_pend = 0;
  bit         rx_rand  = 0;
  bit         txe_rand = 0;
  bit         hold_arm = 0;
  int         txe_hold = 0;
  int         err_cnt  = 0;
  bit         hist  [5];
  logic [7:0] dpipe [5];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Register file contents as seen by reads: a fixed function of address and index.
  function automatic logic [7:0] dval(input logic [AW-1:0] a, input logic [LW-1:0] i);
    int v;
    v = int'(a) * 37 + int'(i) * 11 + 90;
    return 8'(v);
  endfunction

  function automatic logic [63:0] outs_a();
    return 64'({bus.cmdfifo_rd, bus.cmdfifo_wr, bus.cmdfifo_dout, bus.cmdfifo_isout,
                bus.reg_read, bus.reg_write, bus.reg_addrvalid, err_timeout, bus.reg_datao});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({bus.reg_address, bus.reg_hypaddress, bus.reg_size, bus.reg_bytecnt});
  endfunction

  task automatic observe();
    ev_t e;
    if (bus.reg_write) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", bus.reg_address, e.addr);
        check("wr_idx",  bus.reg_bytecnt, e.idx);
        check("wr_data", bus.reg_datao,   e.data);
        check("wr_size", bus.reg_size,    e.size);
      end
    end
    if (bus.reg_read) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = exp_rd.pop_front();
        check("rd_addr",  bus.reg_address,   e.addr);
        check("rd_idx",   bus.reg_bytecnt,   e.idx);
        check("rd_valid", bus.reg_addrvalid, 1);
        check("rd_isout", bus.cmdfifo_isout, 1);
      end
    end
    if (bus.cmdfifo_wr) begin
      check("tx_txe",   bus.cmdfifo_txe,   0);
      check("tx_isout", bus.cmdfifo_isout, 1);
      if (exp_out.size() == 0) check("tx_unexpected", 1, 0);
      else check("tx_data", bus.cmdfifo_dout, exp_out.pop_front());
      if (hold_arm) begin
        txe_hold = 11;
        hold_arm = 0;
      end
    end
    if (err_timeout) err_cnt++;
  endtask

  // One clock: host FIFO and register file update at negedge, DUT sampled 1ns later.
  task automatic tick();
    @(negedge clk);
    if (pop_pend && host_q.size() != 0) void'(host_q.pop_front());
    for (int k = 4; k > 0; k--) begin
      hist[k]  = hist[k-1];
      dpipe[k] = dpipe[k-1];
    end
    hist[0]  = bus.reg_read;
    dpipe[0] = dval(bus.reg_address, bus.reg_bytecnt);
    bus.reg_datai   = hist[RL] ? dpipe[RL] : 8'($urandom);
    bus.reg_hyplen  = hyp[bus.reg_hypaddress];
    bus.cmdfifo_rxf = (host_q.size() != 0) && (!rx_rand || ($urandom_range(0, 3) != 0));
    bus.cmdfifo_din = (host_q.size() != 0) ? host_q[0] : 8'($urandom);
    if (txe_hold > 0) txe_hold--;
    bus.cmdfifo_txe = (txe_hold > 0) || (txe_rand && ($urandom_range(0, 2) == 0));
    #1;
    pop_pend = bus.cmdfifo_rd;
    observe();
  endtask

  task automatic send_cmd(input bit wr, input int addr, input int len, input int d0);
    logic [AW-1:0] a;
    int            eff;
    ev_t           e;
    logic [7:0]    d;
    a   = AW'(addr);
    eff = (hyp[a] != 0 && len > int'(hyp[a])) ? int'(hyp[a]) : len;
    host_q.push_back(8'(8'h80 | (wr ? 8'h40 : 8'h00) | (addr & 63)));
    if (AW > 6) host_q.push_back(8'((addr >> 6) | ($urandom_range(0, 63) << (AW - 6))));
    for (int b = 0; b < LB; b++) host_q.push_back(8'(len >> (8 * b)));
    for (int i = 0; i < len; i++) begin
      e.addr = a;
      e.idx  = LW'(i);
      e.size = LW'(len);
      if (wr) begin
        d = (i == 0 && d0 >= 0) ? 8'(d0) : 8'($urandom);
        host_q.push_back(d);
        e.data = d;
        if (i < eff) exp_wr.push_back(e);
      end else begin
        e.data = 8'h00;
        if (i < eff) exp_rd.push_back(e);
        exp_out.push_back((i < eff) ? dval(a, LW'(i)) : 8'h00);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((host_q.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
            exp_out.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", (n < budget), 1);
    repeat (8) tick();
    check("drain_rx_left",  host_q.size(),  0);
    check("drain_wr_left",  exp_wr.size(),  0);
    check("drain_rd_left",  exp_rd.size(),  0);
    check("drain_tx_left",  exp_out.size(), 0);
    check("idle_addrvalid", bus.reg_addrvalid, 0);
    check("idle_isout",     bus.cmdfifo_isout, 0);
    host_q.delete();
    exp_wr.delete();
    exp_rd.delete();
    exp_out.delete();
  endtask

  initial begin
    int n;
    bus.cmdfifo_rxf = 1'b0;
    bus.cmdfifo_din = 8'h00;
    bus.cmdfifo_txe = 1'b0;
    bus.reg_hyplen  = '0;
    bus.reg_datai   = 8'h00;
    for (int i = 0; i < 256; i++) hyp[i] = '0;
    for (int k = 0; k < 5; k++) begin
      hist[k]  = 1'b0;
      dpipe[k] = 8'h00;
    end

    #1 reset_n = 1'b0;
    #1;
    check("reset_outs_a", outs_a(), 0);
    check("reset_outs_b", outs_b(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single-byte write and read to address 4.
    send_cmd(1, 4, 1, 'hAC);
    drain(200);
    send_cmd(0, 4, 1, -1);
    drain(200);

    // Read of 4 with TX held full for 10 cycles after the first push.
    hold_arm = 1;
    send_cmd(0, 4, 4, -1);
    drain(300);
    hold_arm = 0;

    // Length clamped by declared register size.
    hyp[9] = 1;
    send_cmd(1, 9, 3, -1);
    send_cmd(0, 9, 3, -1);
    drain(300);
    hyp[9] = 0;

    // Zero length, stray non-header byte, high address.
    send_cmd(1, 5, 0, -1);
    host_q.push_back(8'h12);
    send_cmd(0, 8'hB7, 2, -1);
    send_cmd(1, 8'hFE, 2, -1);
    drain(300);

    // Randomised traffic with RX gaps and TX back-pressure.
    for (int i = 0; i < 12; i++) hyp[$urandom_range(0, 255)] = LW'($urandom_range(1, 4));
    rx_rand  = 1;
    txe_rand = 1;
    for (int blk = 0; blk < 10; blk++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 4) == 0) host_q.push_back(8'($urandom_range(0, 127)));
        send_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 6), -1);
      end
      drain(3000);
    end
    check("no_spurious_timeout", err_cnt, 0);
    rx_rand  = 0;
    txe_rand = 0;
    for (int i = 0; i < 256; i++) hyp[i] = '0;

    // Asynchronous reset in the middle of a read.
    txe_rand = 1;
    send_cmd(0, 3, 8, -1);
    n = 0;
    while (!bus.cmdfifo_isout && n < 100) begin
      tick();
      n++;
    end
    check("reach_read_phase", bus.cmdfifo_isout, 1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("midread_reset_a", outs_a(), 0);
    check("midread_reset_b", outs_b(), 0);
    host_q.delete();
    exp_wr.delete();
    exp_rd.delete();
    exp_out.delete();
    pop_pend = 0;
    txe_rand = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_reset_a", outs_a(), 0);
    send_cmd(1, 4, 1, 'hAC);
    drain(200);

`ifdef REG_CMD_BRIDGE_TIMEOUT_EN
    // Command stalls after the first length byte; expect one abort pulse.
    err_cnt = 0;
    host_q.push_back(8'hC4);
    host_q.push_back(8'h00);
    host_q.push_back(8'h01);
    repeat (40) tick();
    check("timeout_pulses", err_cnt, 1);
    check("timeout_addrvalid", bus.reg_addrvalid, 0);
    send_cmd(1, 4, 1, 'hAC);
    drain(200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "global timeout");
  end
endmodule
